// File: rtl/game_screen_pager_if.sv
// Pixel-stream bundle between the OLED driver / art decoder and the screen pager.
interface game_screen_pager_if #(
    parameter int PW = 2
);
    // No back-pressure anywhere: frame_begin is a one-cycle strobe, x/y/pix_fg/pix_hl are valid
    // every cycle, oled_data answers them one cycle later, page_idx feeds the decoder directly.
    logic          frame_begin;
    logic [6:0]    x;
    logic [5:0]    y;
    logic          pix_fg;
    logic          pix_hl;
    logic [PW-1:0] page_idx;
    logic [15:0]   oled_data;

    modport master (output frame_begin, x, y, pix_fg, pix_hl, input page_idx, oled_data);
    modport slave  (input frame_begin, x, y, pix_fg, pix_hl, output page_idx, oled_data);
endinterface

// File: rtl/game_screen_pager.sv
// N-page instruction/menu pager: button navigation, wipe transition, blink layer,
// page-indicator dots and optional idle auto-advance on the 96x64 OLED stream.
module game_screen_pager #(
    parameter int          N_PAGES      = 4,
    parameter int          BLINK_FRAMES = 15,
    parameter int          IDLE_FRAMES  = 0,
    parameter int          WIPE_STEP    = 8,
    parameter logic [15:0] FG           = 16'h0000,
    parameter logic [15:0] BG           = 16'hFFFF,
    parameter logic [15:0] HL           = 16'hF800,
    parameter logic [15:0] DOT_ON       = 16'h001F,
    parameter logic [15:0] DOT_OFF      = 16'h8410
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               btn_sel,
    game_screen_pager_if.slave pix,
    output logic               done,
    output logic               active,
    output logic [1:0]         state_dbg
);
    localparam int PW = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int IW = (IDLE_FRAMES > 0) ? $clog2(IDLE_FRAMES + 1) : 1;
    localparam logic [PW-1:0] LAST       = PW'(N_PAGES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_FRAMES);
    localparam logic [7:0]    WIPE_END   = 8'd96;

    typedef enum logic [1:0] {SHOW = 2'd0, WIPE = 2'd1, DONE = 2'd2} state_t;
    state_t state;

    // Button vectors are ordered {sel, prev, next}.
    logic [2:0]    btn_lvl, lvl_q, edge_q;
    logic [PW-1:0] page;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    wipe_col;
    logic          go_next, go_prev, go_done, page_chg;
    logic [8:0]    wipe_sum;
    logic          is_dot, dot_cur;
    logic [15:0]   pix_next;

    assign btn_lvl      = {btn_sel, btn_prev, btn_next};
    assign pix.page_idx = page;
    assign state_dbg    = state;

    always_comb begin
        go_next = 1'b0;
        go_prev = 1'b0;
        go_done = 1'b0;
        if (state == SHOW) begin
            if (edge_q[2]) begin
                if (page == LAST) go_done = 1'b1;
                else              go_next = 1'b1;
            end else if (edge_q[0] && !edge_q[1]) begin
                go_next = (page != LAST);
            end else if (edge_q[1] && !edge_q[0]) begin
                go_prev = (page != '0);
            end else if (edge_q == 3'b000 && IDLE_FRAMES != 0 &&
                         idle_cnt == IDLE_MAX && page != LAST) begin
                go_next = 1'b1;
            end
        end
        page_chg = go_next | go_prev;
        wipe_sum = {1'b0, wipe_col} + 9'(WIPE_STEP);
    end

    always_comb begin
        is_dot  = (pix.y == 6'd60 || pix.y == 6'd61) && pix.x[1] &&
                  ({2'b00, pix.x[6:2]} < 7'(N_PAGES));
        dot_cur = ({2'b00, pix.x[6:2]} == 7'(page));
        if (state == DONE)                                    pix_next = BG;
        else if (is_dot)                                      pix_next = dot_cur ? DOT_ON : DOT_OFF;
        else if (state == WIPE && {1'b0, pix.x} >= wipe_col)  pix_next = BG;
        else if (pix.pix_fg)                                  pix_next = FG;
        else if (pix.pix_hl && blink_on)                      pix_next = HL;
        else                                                  pix_next = BG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q         <= 3'b111;
            edge_q        <= 3'b000;
            state         <= SHOW;
            page          <= '0;
            blink_cnt     <= '0;
            blink_on      <= 1'b1;
            idle_cnt      <= '0;
            wipe_col      <= '0;
            done          <= 1'b0;
            active        <= 1'b1;
            pix.oled_data <= BG;
        end else begin
            lvl_q         <= btn_lvl;
            edge_q        <= btn_lvl & ~lvl_q;
            done          <= 1'b0;
            pix.oled_data <= pix_next;

            // A page change on a frame_begin cycle swallows that frame for every counter.
            if (page_chg) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (pix.frame_begin) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            if (page_chg || edge_q != 3'b000)
                idle_cnt <= '0;
            else if (state == SHOW && pix.frame_begin && idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;

            case (state)
                SHOW: begin
                    if (go_done) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        active <= 1'b0;
                    end else if (page_chg) begin
                        state    <= WIPE;
                        wipe_col <= '0;
                        page     <= go_next ? page + 1'b1 : page - 1'b1;
                    end
                end
                WIPE: begin
                    if (wipe_col >= WIPE_END)
                        state <= SHOW;
                    else if (pix.frame_begin)
                        wipe_col <= wipe_sum[8] ? 8'hFF : wipe_sum[7:0];
                end
                DONE: begin
                    if (edge_q[1]) begin
                        state  <= SHOW;
                        page   <= LAST;
                        active <= 1'b1;
                    end
                end
                default: begin
                    state  <= SHOW;
                    active <= 1'b1;
                end
            endcase
        end
    end
endmodule
